alu_operand_stage: RTL and testbench
====================================

# alu_operand_stage

Operand-fetch / writeback stage wrapped around the combinational ALU. It accepts issued ALU micro-ops over a valid/ready handshake and reads operands from a 16×32 register file it owns. It drives registered `a`/`b`/`opcode` into the ALU, then captures the ALU `out` into a result register and writes it back to the register file. Hazards on back-to-back dependent ops are resolved by bypass, so there is no stall. Throughput is one op per cycle.

## Interface
Parameters:
- `IMM_W`, 12, width of the immediate operand; zero-extended to 32 bits.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `iss_valid`  in  1  issue request valid.
- `iss_ready`  out  1  stage can accept an issue this cycle.
- `iss_opcode`  in  4  ALU opcode, passed through unchanged.
- `iss_rd`  in  4  destination register.
- `iss_rn`  in  4  source register for `a`.
- `iss_rm`  in  4  source register for `b`; ignored when `iss_use_imm` is set.
- `iss_use_imm`  in  1  when set, `b` = zero-extended `iss_imm`.
- `iss_imm`  in  `IMM_W`  immediate value.
- `alu_a`, `alu_b`  out  32  registered operands to the ALU.
- `alu_opcode`  out  4  registered opcode to the ALU.
- `alu_out`  in  32  combinational ALU result.
- `res_valid`  out  1  result register holds a completed op.
- `res_ready`  in  1  consumer accepts the result.
- `res_data`  out  32  completed result.
- `res_rd`  out  4  destination register of the completed result.
- `ext_we`  in  1  external register-file write, used for preload and debug.
- `ext_addr`  in  4  external write address.
- `ext_wdata`  in  32  external write data.

## Operation
- **Pipeline.** The stage has two register slots:
  - EX: `alu_a`, `alu_b`, `alu_opcode`, `rd_q`, `ex_valid`.
  - WB: `res_data`, `res_rd`, `res_valid`.
- **Control terms.**
  - `wb_adv` = `!res_valid || res_ready`.
  - `ex_adv` = `ex_valid && wb_adv`.
  - `iss_ready` = `!ex_valid || wb_adv` (combinational).
- **Issue.** Issue is accepted when `iss_valid && iss_ready`. On accept, EX loads the resolved operands, `iss_opcode` and `iss_rd`, and sets `ex_valid`=1.
- **EX drain.** When `ex_adv` is true and no new issue is accepted, `ex_valid` goes to 0. `alu_a`, `alu_b` and `alu_opcode` then hold their last values.
- **EX → WB.** On `ex_adv`:
  - `res_data` ← `alu_out`, `res_rd` ← `rd_q`, `res_valid` ← 1.
  - `regfile[rd_q]` ← `alu_out` on the same edge.
- **WB clear.** `res_valid` goes to 0 when `res_ready` is high and `ex_adv` is false.
- **Operand resolution.** Each source is resolved independently, in this priority order:
  1. If `ex_adv` and `rd_q` equals the source index, the value is `alu_out` (bypass).
  2. Else if `ext_we` and `ext_addr` equals the source index, the value is `ext_wdata`.
  3. Else the value is `regfile[idx]`.
- **Write collision.** If `ex_adv` and `ext_we` target the same register on the same edge, the pipeline write wins. An external write to a different register proceeds on that edge.
- **Opcodes.** The opcode is not checked. Invalid opcodes produce whatever the ALU returns (0), which is written back normally.
- **Registers.** No register is special; r15 is an ordinary register in this stage.
- **Reset.** Asserting `rst_n` low, including mid-operation, immediately clears everything below; in-flight ops are discarded.
  - Outputs: `ex_valid`, `res_valid`, `alu_a`, `alu_b`, `alu_opcode`, `res_data`, `res_rd` all go to 0.
  - All 16 registers go to 0.
  - `iss_ready` reads 1 while in reset and immediately after.

## Timing
- **Latency.** An issue accepted at edge N places operands on `alu_*` during cycle N..N+1. `res_valid`=1 and the register file is updated at edge N+1.
- **Throughput.** One op per cycle with `res_ready` tied high, including back-to-back dependent ops (zero bubbles).
- **Backpressure.** While `res_valid && !res_ready`:
  - WB holds.
  - EX holds if occupied.
  - `iss_ready`=0 if EX is occupied.
  - `alu_*`, `res_*` and the register file are stable.
- **Register-file read.** Asynchronous, plus the bypass described above.
- **Register-file write.** Synchronous, on the rising edge.

## Test plan
- **Reset values.** Assert `rst_n`=0 mid-stream → all outputs 0, `iss_ready`=1. Afterwards, issue ADD r1=r2+r3 → `res_data`=0.
- **Basic ADD.** Preload r2=5 and r3=7 via `ext_we`. Issue ADD (0000) rd=r1 → `alu_a`=5 and `alu_b`=7 after 1 edge; `res_valid`=1, `res_data`=12, `res_rd`=1 after 2 edges; r1 reads 12.
- **Back-to-back bypass.** Issue r1=r2+r3 (12), then immediately SUB (0001) r4=r1−r2 with no idle cycle → second `alu_a`=12, `res_data`=7, no bubble.
- **Immediate operand.** Issue XOR (0100) rn=r2 (value 5), `use_imm`=1, imm=12'hFFF → `alu_b`=32'h00000FFF, `res_data`=32'h00000FFA.
- **Backpressure.** With `res_ready`=0, issue 3 ops → `iss_ready` drops after the 2nd accept; `res_data` is held 3 cycles. Release `res_ready` → all 3 results appear in order, and the 3rd op is accepted on the first cycle `res_ready`=1 (re-asserting `iss_ready` in the same cycle).
- **Write collision.** Pipeline write to r6=9 and `ext_we` r6=1 on the same edge → r6=9. On another edge, `ext_we` r7=3 while issuing an op that reads r7 in the same cycle → operand =3.

Source files
------------

// File: rtl/alu_operand_stage.sv
// Operand-fetch / writeback stage around a combinational ALU: owns a 16x32
// register file, registers operands into EX, captures ALU results into WB.
module alu_operand_stage #(
  parameter int IMM_W = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             iss_valid,
  output logic             iss_ready,
  input  logic [3:0]       iss_opcode,
  input  logic [3:0]       iss_rd,
  input  logic [3:0]       iss_rn,
  input  logic [3:0]       iss_rm,
  input  logic             iss_use_imm,
  input  logic [IMM_W-1:0] iss_imm,
  output logic [31:0]      alu_a,
  output logic [31:0]      alu_b,
  output logic [3:0]       alu_opcode,
  input  logic [31:0]      alu_out,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [31:0]      res_data,
  output logic [3:0]       res_rd,
  input  logic             ext_we,
  input  logic [3:0]       ext_addr,
  input  logic [31:0]      ext_wdata
);

  logic [15:0][31:0] rf_q, rf_d;
  logic [31:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d, res_data_q, res_data_d;
  logic [3:0]  alu_opcode_q, alu_opcode_d, rd_q, rd_d, res_rd_q, res_rd_d;
  logic        ex_valid_q, ex_valid_d, res_valid_q, res_valid_d;
  logic        wb_adv, ex_adv, iss_fire;
  logic [31:0] opa, opb;

  assign wb_adv    = !res_valid_q || res_ready;
  assign ex_adv    = ex_valid_q && wb_adv;
  assign iss_ready = !ex_valid_q || wb_adv;
  assign iss_fire  = iss_valid && iss_ready;

  // Bypass from the op retiring this edge beats a same-edge external write.
  always_comb begin
    opa = rf_q[iss_rn];
    if (ex_adv && rd_q == iss_rn)        opa = alu_out;
    else if (ext_we && ext_addr == iss_rn) opa = ext_wdata;

    opb = rf_q[iss_rm];
    if (iss_use_imm)                     opb = {{(32-IMM_W){1'b0}}, iss_imm};
    else if (ex_adv && rd_q == iss_rm)   opb = alu_out;
    else if (ext_we && ext_addr == iss_rm) opb = ext_wdata;
  end

  always_comb begin
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    alu_opcode_d = alu_opcode_q;
    rd_d         = rd_q;
    ex_valid_d   = ex_valid_q;
    if (iss_fire) begin
      alu_a_d      = opa;
      alu_b_d      = opb;
      alu_opcode_d = iss_opcode;
      rd_d         = iss_rd;
      ex_valid_d   = 1'b1;
    end else if (ex_adv) begin
      ex_valid_d   = 1'b0;
    end
  end

  always_comb begin
    res_data_d  = res_data_q;
    res_rd_d    = res_rd_q;
    res_valid_d = res_valid_q;
    if (ex_adv) begin
      res_data_d  = alu_out;
      res_rd_d    = rd_q;
      res_valid_d = 1'b1;
    end else if (res_ready) begin
      res_valid_d = 1'b0;
    end
  end

  // Pipeline writeback is applied last so it wins a same-register collision.
  always_comb begin
    rf_d = rf_q;
    if (ext_we) rf_d[ext_addr] = ext_wdata;
    if (ex_adv) rf_d[rd_q]     = alu_out;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_q         <= '0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_opcode_q <= '0;
      rd_q         <= '0;
      ex_valid_q   <= 1'b0;
      res_data_q   <= '0;
      res_rd_q     <= '0;
      res_valid_q  <= 1'b0;
    end else begin
      rf_q         <= rf_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      alu_opcode_q <= alu_opcode_d;
      rd_q         <= rd_d;
      ex_valid_q   <= ex_valid_d;
      res_data_q   <= res_data_d;
      res_rd_q     <= res_rd_d;
      res_valid_q  <= res_valid_d;
    end
  end

  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign alu_opcode = alu_opcode_q;
  assign res_valid  = res_valid_q;
  assign res_data   = res_data_q;
  assign res_rd     = res_rd_q;

endmodule

// File: tb/tb_alu_operand_stage.sv
// Directed bench for alu_operand_stage with a small behavioural ALU attached.
module tb_alu_operand_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        iss_valid, iss_ready, iss_use_imm;
  logic [3:0]  iss_opcode, iss_rd, iss_rn, iss_rm;
  logic [11:0] iss_imm;
  logic [31:0] alu_a, alu_b, alu_out;
  logic [3:0]  alu_opcode;
  logic        res_valid, res_ready;
  logic [31:0] res_data;
  logic [3:0]  res_rd;
  logic        ext_we;
  logic [3:0]  ext_addr;
  logic [31:0] ext_wdata;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  // Environment ALU: ADD, SUB, AND, OR, XOR; anything else returns 0.
  always_comb begin
    case (alu_opcode)
      4'd0:    alu_out = alu_a + alu_b;
      4'd1:    alu_out = alu_a - alu_b;
      4'd2:    alu_out = alu_a & alu_b;
      4'd3:    alu_out = alu_a | alu_b;
      4'd4:    alu_out = alu_a ^ alu_b;
      default: alu_out = 32'd0;
    endcase
  end

  alu_operand_stage #(.IMM_W(12)) dut (
    .clk(clk), .rst_n(rst_n),
    .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_opcode(iss_opcode),
    .iss_rd(iss_rd), .iss_rn(iss_rn), .iss_rm(iss_rm),
    .iss_use_imm(iss_use_imm), .iss_imm(iss_imm),
    .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode), .alu_out(alu_out),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_rd(res_rd),
    .ext_we(ext_we), .ext_addr(ext_addr), .ext_wdata(ext_wdata)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [3:0] op, input logic [3:0] rd, input logic [3:0] rn,
                       input logic [3:0] rm, input logic use_imm, input logic [11:0] imm);
    iss_valid = 1'b1; iss_opcode = op; iss_rd = rd; iss_rn = rn; iss_rm = rm;
    iss_use_imm = use_imm; iss_imm = imm;
  endtask

  task automatic ext_wr(input logic [3:0] a, input logic [31:0] d);
    ext_we = 1'b1; ext_addr = a; ext_wdata = d;
    tick();
    ext_we = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; iss_valid = 1'b0; iss_opcode = '0; iss_rd = '0; iss_rn = '0; iss_rm = '0;
    iss_use_imm = 1'b0; iss_imm = '0; res_ready = 1'b1;
    ext_we = 1'b0; ext_addr = '0; ext_wdata = '0;
    #12;
    chk("rst_iss_ready", {31'd0, iss_ready}, 32'd1);
    chk("rst_res_valid", {31'd0, res_valid}, 32'd0);
    chk("rst_alu_a", alu_a, 32'd0);
    rst_n = 1'b1;
    tick();

    // Basic ADD r1 = r2 + r3
    ext_wr(4'd2, 32'd5);
    ext_wr(4'd3, 32'd7);
    issue(4'd0, 4'd1, 4'd2, 4'd3, 1'b0, 12'd0);
    tick();
    iss_valid = 1'b0;
    chk("add_alu_a", alu_a, 32'd5);
    chk("add_alu_b", alu_b, 32'd7);
    chk("add_res_valid_early", {31'd0, res_valid}, 32'd0);
    tick();
    chk("add_res_valid", {31'd0, res_valid}, 32'd1);
    chk("add_res_data", res_data, 32'd12);
    chk("add_res_rd", {28'd0, res_rd}, 32'd1);
    tick();
    chk("add_res_clear", {31'd0, res_valid}, 32'd0);
    // r1 readback through a follow-up op
    issue(4'd0, 4'd9, 4'd1, 4'd0, 1'b0, 12'd0);
    tick();
    iss_valid = 1'b0;
    tick();
    chk("r1_readback", res_data, 32'd12);
    tick();

    // Back-to-back dependent ops: r1 = r2 + r3, r4 = r1 - r2
    issue(4'd0, 4'd1, 4'd2, 4'd3, 1'b0, 12'd0);
    tick();
    issue(4'd1, 4'd4, 4'd1, 4'd2, 1'b0, 12'd0);
    chk("b2b_iss_ready", {31'd0, iss_ready}, 32'd1);
    tick();
    iss_valid = 1'b0;
    chk("b2b_bypass_a", alu_a, 32'd12);
    chk("b2b_first_res", res_data, 32'd12);
    tick();
    chk("b2b_sub_res", res_data, 32'd7);
    chk("b2b_sub_rd", {28'd0, res_rd}, 32'd4);
    chk("b2b_no_bubble", {31'd0, res_valid}, 32'd1);
    tick();

    // Immediate XOR r5 = r2 ^ 0xFFF
    issue(4'd4, 4'd5, 4'd2, 4'd9, 1'b1, 12'hFFF);
    tick();
    iss_valid = 1'b0;
    chk("imm_alu_b", alu_b, 32'h0000_0FFF);
    tick();
    chk("imm_res", res_data, 32'h0000_0FFA);
    tick();

    // Backpressure with three ops
    res_ready = 1'b0;
    issue(4'd0, 4'd10, 4'd2, 4'd0, 1'b0, 12'd0);
    tick();
    issue(4'd0, 4'd11, 4'd3, 4'd0, 1'b0, 12'd0);
    chk("bp_ready_2nd", {31'd0, iss_ready}, 32'd1);
    tick();
    issue(4'd0, 4'd12, 4'd2, 4'd3, 1'b0, 12'd0);
    chk("bp_ready_drop", {31'd0, iss_ready}, 32'd0);
    chk("bp_res0", res_data, 32'd5);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bp_res_hold", res_data, 32'd5);
      chk("bp_alu_a_hold", alu_a, 32'd7);
      chk("bp_ready_low", {31'd0, iss_ready}, 32'd0);
    end
    res_ready = 1'b1;
    #1;
    chk("bp_ready_release", {31'd0, iss_ready}, 32'd1);
    tick();
    iss_valid = 1'b0;
    chk("bp_res2", res_data, 32'd7);
    chk("bp_rd2", {28'd0, res_rd}, 32'd11);
    chk("bp_op3_in_ex", alu_a, 32'd5);
    tick();
    chk("bp_res3", res_data, 32'd12);
    chk("bp_rd3", {28'd0, res_rd}, 32'd12);
    tick();
    chk("bp_drained", {31'd0, res_valid}, 32'd0);

    // Write collision: pipeline r6 = 5 + 4 vs external r6 = 1
    issue(4'd0, 4'd6, 4'd2, 4'd0, 1'b1, 12'd4);
    tick();
    iss_valid = 1'b0;
    ext_wr(4'd6, 32'd1);
    issue(4'd0, 4'd13, 4'd6, 4'd0, 1'b0, 12'd0);
    tick();
    iss_valid = 1'b0;
    tick();
    chk("coll_r6", res_data, 32'd9);
    // External write forwarded into an operand on the same edge
    ext_we = 1'b1; ext_addr = 4'd7; ext_wdata = 32'd3;
    issue(4'd0, 4'd14, 4'd7, 4'd0, 1'b0, 12'd0);
    tick();
    ext_we = 1'b0; iss_valid = 1'b0;
    chk("ext_fwd_a", alu_a, 32'd3);
    tick();

    // Invalid opcode writes back 0 into r15
    issue(4'd15, 4'd15, 4'd2, 4'd3, 1'b0, 12'd0);
    tick();
    iss_valid = 1'b0;
    tick();
    chk("bad_op_res", res_data, 32'd0);
    chk("bad_op_rd", {28'd0, res_rd}, 32'd15);
    tick();

    // Reset mid-stream
    issue(4'd0, 4'd8, 4'd2, 4'd3, 1'b0, 12'd0);
    tick();
    iss_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_alu_a", alu_a, 32'd0);
    chk("mid_rst_alu_b", alu_b, 32'd0);
    chk("mid_rst_res_data", res_data, 32'd0);
    chk("mid_rst_res_valid", {31'd0, res_valid}, 32'd0);
    chk("mid_rst_iss_ready", {31'd0, iss_ready}, 32'd1);
    tick();
    rst_n = 1'b1;
    #1;
    chk("post_rst_iss_ready", {31'd0, iss_ready}, 32'd1);
    issue(4'd0, 4'd1, 4'd2, 4'd3, 1'b0, 12'd0);
    tick();
    iss_valid = 1'b0;
    tick();
    chk("post_rst_valid", {31'd0, res_valid}, 32'd1);
    chk("post_rst_res", res_data, 32'd0);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
